// File: rtl/bias_loader_pkg.sv
// Shared constants, FSM state type and count-width helper for the bias loader.
// Optional feature macro: BIAS_LOADER_ZERO_FILL_EN (see bias_loader.sv).
package bias_loader_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_e;

    // Width of a lane index; never narrower than one bit so SIZE=1 stays legal.
    function automatic int clog2(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/bias_shadow_buffer.sv
// SIZE x 8 lane-addressed shadow register file.
// Supports one lane write plus zero-fill of every lane at or above an index.
module bias_shadow_buffer
    import bias_loader_pkg::*;
#(
    parameter int SIZE = 16,
    localparam int CW = clog2(SIZE)
) (
    input  logic                     clock_i,
    input  logic                     reset_ni,
    input  logic                     we_i,
    input  logic [CW-1:0]            idx_i,
    input  logic [BYTE_W-1:0]        data_i,
    input  logic                     zfill_i,
    input  logic [CW:0]              zidx_i,
    output logic [BYTE_W*SIZE-1:0]   lanes_o
);

    logic [BYTE_W*SIZE-1:0] lanes_q;
    logic [BYTE_W*SIZE-1:0] lanes_d;

    // A lane write takes priority; zero-fill then starts at the caller's index.
    always_comb begin
        lanes_d = lanes_q;
        for (int i = 0; i < SIZE; i++) begin
            if (we_i && (idx_i == CW'(i))) begin
                lanes_d[i*BYTE_W +: BYTE_W] = data_i;
            end else if (zfill_i && ((CW+1)'(i) >= zidx_i)) begin
                lanes_d[i*BYTE_W +: BYTE_W] = '0;
            end
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            lanes_q <= '0;
        end else begin
            lanes_q <= lanes_d;
        end
    end

    assign lanes_o = lanes_q;

endmodule

// File: rtl/bias_loader.sv
// Double-buffered per-lane bias loader: serial byte fill, parallel swap-out.
// Define BIAS_LOADER_ZERO_FILL_EN to add the flush port (pad a partial set with zeros).
module bias_loader
    import bias_loader_pkg::*;
#(
    parameter int SIZE = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [BYTE_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     swap,
`ifdef BIAS_LOADER_ZERO_FILL_EN
    input  logic                     flush,
`endif
    output logic [BYTE_W*SIZE-1:0]   bias_out,
    output logic                     bias_valid,
    output logic                     shadow_full
);

    localparam int CW = clog2(SIZE);
    localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

    state_e                   state_q, state_d;
    logic [CW-1:0]            count_q, count_d;
    logic [BYTE_W*SIZE-1:0]   active_q, active_d;
    logic                     valid_q, valid_d;
    logic [BYTE_W*SIZE-1:0]   shadow;
    logic                     accept;
    logic                     zfill;
    logic [CW:0]              zidx;

    assign in_ready    = (state_q == FILL);
    assign shadow_full = (state_q == FULL);
    assign accept      = in_valid & in_ready;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        active_d = active_q;
        valid_d  = valid_q;
        zfill    = 1'b0;
        zidx     = '0;
        unique case (state_q)
            FILL: begin
                if (accept) begin
                    if (count_q == LAST) begin
                        count_d = '0;
                        state_d = FULL;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
`ifdef BIAS_LOADER_ZERO_FILL_EN
                // Same-cycle byte lands first, so padding begins one lane later.
                if (flush && (count_q != '0) && (state_d == FILL)) begin
                    zfill   = 1'b1;
                    zidx    = {1'b0, count_q} + {{CW{1'b0}}, accept};
                    count_d = '0;
                    state_d = FULL;
                end
`endif
            end
            FULL: begin
                if (swap) begin
                    active_d = shadow;
                    valid_d  = 1'b1;
                    state_d  = FILL;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= FILL;
            count_q  <= '0;
            active_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            active_q <= active_d;
            valid_q  <= valid_d;
        end
    end

    bias_shadow_buffer #(
        .SIZE (SIZE)
    ) u_shadow (
        .clock_i  (clock),
        .reset_ni (reset),
        .we_i     (accept),
        .idx_i    (count_q),
        .data_i   (in_data),
        .zfill_i  (zfill),
        .zidx_i   (zidx),
        .lanes_o  (shadow)
    );

    assign bias_out   = active_q;
    assign bias_valid = valid_q;

endmodule

// File: tb/tb_bias_loader.sv
// Self-checking bench for bias_loader (SIZE=4 main instance, SIZE=1 regression).
// Reference model: a queue of accepted bytes packed into a set when complete.
module tb_bias_loader;

    localparam int SZ = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        swap;
    logic        flush;
    logic        in_ready;
    logic [31:0] bias_out;
    logic        bias_valid;
    logic        shadow_full;

    logic [7:0]  d1;
    logic        v1, s1, f1;
    logic        r1;
    logic [7:0]  bo1;
    logic        bv1, sf1;

    int checks = 0;
    int errors = 0;

    logic [7:0]  q_set[$];
    logic [31:0] m_shadow;
    logic [31:0] m_bias;
    bit          m_full;
    bit          m_valid;

    always #5 clock = ~clock;

    bias_loader #(.SIZE(SZ)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .swap        (swap),
`ifdef BIAS_LOADER_ZERO_FILL_EN
        .flush       (flush),
`endif
        .bias_out    (bias_out),
        .bias_valid  (bias_valid),
        .shadow_full (shadow_full)
    );

    bias_loader #(.SIZE(1)) dut1 (
        .clock       (clock),
        .reset       (reset),
        .in_data     (d1),
        .in_valid    (v1),
        .in_ready    (r1),
        .swap        (s1),
`ifdef BIAS_LOADER_ZERO_FILL_EN
        .flush       (f1),
`endif
        .bias_out    (bo1),
        .bias_valid  (bv1),
        .shadow_full (sf1)
    );

    task automatic model_reset();
        q_set.delete();
        m_shadow = '0;
        m_bias   = '0;
        m_full   = 1'b0;
        m_valid  = 1'b0;
    endtask

    // One clock of stimulus; the model advances from its pre-edge state.
    task automatic drive(input logic v, input logic [7:0] d,
                         input logic s, input logic f);
        bit was_full;
        bit had;
        in_valid = v;
        in_data  = d;
        swap     = s;
        flush    = f;
        was_full = m_full;
        had      = (q_set.size() > 0);
        @(posedge clock);
        #1;
        if (was_full) begin
            if (s) begin
                m_bias  = m_shadow;
                m_valid = 1'b1;
                m_full  = 1'b0;
            end
        end else begin
            if (v) q_set.push_back(d);
`ifdef BIAS_LOADER_ZERO_FILL_EN
            if (f && had)
                while (q_set.size() < SZ) q_set.push_back(8'h00);
`else
            if (f && had) begin end
`endif
            if (q_set.size() == SZ) begin
                for (int i = 0; i < SZ; i++) m_shadow[8*i +: 8] = q_set[i];
                q_set.delete();
                m_full = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        in_valid = 1'b1; in_data = 8'hAA; swap = 1'b0; flush = 1'b0;
        v1 = 1'b1; d1 = 8'h55; s1 = 1'b0; f1 = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        model_reset();
        checks++;
        if (bias_out !== 32'h0) begin
            errors++; $display("FAIL reset_bias got=%h exp=0", bias_out);
        end
        checks++;
        if (bias_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid got=%b exp=0", bias_valid);
        end
        checks++;
        if (shadow_full !== 1'b0) begin
            errors++; $display("FAIL reset_full got=%b exp=0", shadow_full);
        end
        checks++;
        if (bv1 !== 1'b0 || sf1 !== 1'b0) begin
            errors++; $display("FAIL reset_s1 got=%b%b exp=00", bv1, sf1);
        end
        v1 = 1'b0;
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready got=%b exp=1", in_ready);
        end
    endtask

    task automatic test_load_swap();
        drive(1'b1, 8'h01, 1'b0, 1'b0);
        drive(1'b1, 8'hFF, 1'b0, 1'b0);
        drive(1'b1, 8'h7F, 1'b0, 1'b0);
        drive(1'b1, 8'h80, 1'b0, 1'b0);
        checks++;
        if (shadow_full !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL load_full got full=%b rdy=%b exp full=1 rdy=0",
                     shadow_full, in_ready);
        end
        checks++;
        if (bias_valid !== 1'b0) begin
            errors++; $display("FAIL load_novalid got=%b exp=0", bias_valid);
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if (bias_out !== 32'h807FFF01) begin
            errors++; $display("FAIL swap_bias got=%h exp=807fff01", bias_out);
        end
        checks++;
        if (bias_valid !== 1'b1 || in_ready !== 1'b1 || shadow_full !== 1'b0) begin
            errors++;
            $display("FAIL swap_flags got v=%b r=%b f=%b exp v=1 r=1 f=0",
                     bias_valid, in_ready, shadow_full);
        end
    endtask

    task automatic test_overlap();
        logic [31:0] set_a, set_b;
        logic [7:0]  b;
        for (int i = 0; i < SZ; i++) begin
            b = 8'($urandom);
            set_a[8*i +: 8] = b;
            drive(1'b1, b, 1'b0, 1'b0);
        end
        for (int i = 0; i < SZ; i++) set_b[8*i +: 8] = 8'($urandom);
        drive(1'b1, set_b[7:0], 1'b1, 1'b0);
        checks++;
        if (bias_out !== set_a || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ovl_swapA got=%h rdy=%b exp=%h rdy=1",
                     bias_out, in_ready, set_a);
        end
        for (int i = 0; i < SZ; i++) drive(1'b1, set_b[8*i +: 8], 1'b0, 1'b0);
        drive(1'b1, 8'hEE, 1'b0, 1'b0);
        drive(1'b1, 8'hEE, 1'b0, 1'b0);
        checks++;
        if (bias_out !== set_a || shadow_full !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ovl_hold got=%h full=%b rdy=%b exp=%h full=1 rdy=0",
                     bias_out, shadow_full, in_ready, set_a);
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if (bias_out !== set_b || bias_out !== m_bias) begin
            errors++; $display("FAIL ovl_swapB got=%h exp=%h", bias_out, set_b);
        end
    endtask

    task automatic test_ignored_swap();
        logic [31:0] prev, set_c;
        prev = m_bias;
        for (int i = 0; i < SZ; i++) set_c[8*i +: 8] = 8'($urandom);
        drive(1'b1, set_c[7:0], 1'b0, 1'b0);
        drive(1'b1, set_c[15:8], 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if (bias_out !== prev || shadow_full !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ign_swap got=%h full=%b rdy=%b exp=%h full=0 rdy=1",
                     bias_out, shadow_full, in_ready, prev);
        end
        drive(1'b1, set_c[23:16], 1'b0, 1'b0);
        checks++;
        if (shadow_full !== 1'b0) begin
            errors++; $display("FAIL ign_3of4 got=%b exp=0", shadow_full);
        end
        drive(1'b1, set_c[31:24], 1'b1, 1'b0);
        checks++;
        if (shadow_full !== 1'b1 || bias_out !== prev) begin
            errors++;
            $display("FAIL ign_last got full=%b bias=%h exp full=1 bias=%h",
                     shadow_full, bias_out, prev);
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if (bias_out !== set_c) begin
            errors++; $display("FAIL ign_swapC got=%h exp=%h", bias_out, set_c);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) drive(1'b1, 8'($urandom), 1'b0, 1'b0);
        in_valid = 1'b0;
        reset = 1'b0;
        #3;
        model_reset();
        checks++;
        if (bias_valid !== 1'b0 || bias_out !== 32'h0) begin
            errors++;
            $display("FAIL rmid_clear got v=%b b=%h exp v=0 b=0",
                     bias_valid, bias_out);
        end
        reset = 1'b1;
        for (int i = 0; i < SZ; i++) drive(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if (bias_out !== 32'h13121110) begin
            errors++; $display("FAIL rmid_swap got=%h exp=13121110", bias_out);
        end
    endtask

    task automatic test_random();
        logic v, s, f;
        for (int c = 0; c < 300; c++) begin
            v = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 3) == 0);
            f = ($urandom_range(0, 7) == 0);
            drive(v, 8'($urandom), s, f);
            checks++;
            if (bias_out !== m_bias) begin
                errors++;
                $display("FAIL rnd_bias c=%0d got=%h exp=%h", c, bias_out, m_bias);
            end
            checks++;
            if (bias_valid !== m_valid) begin
                errors++;
                $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, bias_valid, m_valid);
            end
            checks++;
            if (shadow_full !== m_full) begin
                errors++;
                $display("FAIL rnd_full c=%0d got=%b exp=%b", c, shadow_full, m_full);
            end
            checks++;
            if (in_ready !== !m_full) begin
                errors++;
                $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, in_ready, !m_full);
            end
        end
    endtask

`ifdef BIAS_LOADER_ZERO_FILL_EN
    task automatic test_flush();
        in_valid = 1'b0;
        reset = 1'b0;
        #3;
        model_reset();
        reset = 1'b1;
        drive(1'b1, 8'h05, 1'b0, 1'b0);
        drive(1'b1, 8'h06, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        checks++;
        if (shadow_full !== 1'b1) begin
            errors++; $display("FAIL flush_full got=%b exp=1", shadow_full);
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if (bias_out !== 32'h00000605) begin
            errors++; $display("FAIL flush_swap got=%h exp=00000605", bias_out);
        end
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        checks++;
        if (shadow_full !== 1'b0) begin
            errors++; $display("FAIL flush_empty got=%b exp=0", shadow_full);
        end
        drive(1'b1, 8'h21, 1'b0, 1'b0);
        drive(1'b1, 8'h22, 1'b0, 1'b1);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if (bias_out !== 32'h00002221) begin
            errors++; $display("FAIL flush_byte got=%h exp=00002221", bias_out);
        end
    endtask
`endif

    task automatic test_size1();
        logic [7:0] b;
        in_valid = 1'b0; swap = 1'b0; flush = 1'b0;
        for (int k = 0; k < 6; k++) begin
            b = 8'($urandom);
            v1 = 1'b1; d1 = b; s1 = 1'b0;
            @(posedge clock);
            #1;
            checks++;
            if (sf1 !== 1'b1 || r1 !== 1'b0) begin
                errors++;
                $display("FAIL s1_full k=%0d got f=%b r=%b exp f=1 r=0", k, sf1, r1);
            end
            v1 = 1'b0; s1 = 1'b1;
            @(posedge clock);
            #1;
            s1 = 1'b0;
            checks++;
            if (bo1 !== b || bv1 !== 1'b1 || r1 !== 1'b1) begin
                errors++;
                $display("FAIL s1_swap k=%0d got=%h v=%b r=%b exp=%h v=1 r=1",
                         k, bo1, bv1, r1, b);
            end
        end
    endtask

    initial begin
        in_valid = 1'b0; in_data = 8'h00; swap = 1'b0; flush = 1'b0;
        v1 = 1'b0; d1 = 8'h00; s1 = 1'b0; f1 = 1'b0;
        test_reset();
        test_load_swap();
        test_overlap();
        test_ignored_swap();
        test_reset_mid();
        test_random();
`ifdef BIAS_LOADER_ZERO_FILL_EN
        test_flush();
`endif
        test_size1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
